id_exe_pipe_reg: RTL and testbench
==================================

# id_exe_pipe_reg

Parametrised ID→EXE pipeline register with valid/ready handshaking, a one-entry skid buffer, and a synchronous flush that inserts a bubble. It sits between the decode stage and the execution stage. It carries PC, destination register, Val1, Val2, Reg2, execution command, and the branch/memory/write-back control bits. Unlike a plain clocked register, it can absorb back-pressure from EXE without losing data and kill in-flight instructions on a branch redirect.

## Interface
- DATA_W, 32: width of PC, Val1, Val2, Reg2
- RADDR_W, 5: width of destination register index
- CMD_W, 5: width of EXE command
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high; clock clk
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  register can accept this cycle
- in_pc, in_val1, in_val2, in_reg2  in  DATA_W each  payload
- in_dest  in  RADDR_W  destination register
- in_exe_cmd  in  CMD_W  EXE command
- in_br_taken, in_mem_r_en, in_mem_w_en, in_wb_en  in  1 each  control bits
- out_valid  out  1  EXE-side instruction valid
- out_ready  in  1  EXE consumes this cycle
- out_pc, out_val1, out_val2, out_reg2, out_dest, out_exe_cmd  out  widths as inputs  payload
- out_br_taken, out_mem_r_en, out_mem_w_en, out_wb_en  out  1 each  control bits, gated by out_valid
- occupancy  out  2  entries held (0, 1, or 2)

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives outputs) and skid entry. Each entry holds the full payload.
- FSM states: EMPTY (occupancy 0), FULL (1), SKID (2).
- in_ready = (state != SKID). It is a decode of the state register, with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- EMPTY: in_fire → FULL, and main ← in.
- FULL with in_fire & out_fire → FULL, and main ← in.
- FULL with in_fire & !out_fire → SKID, and skid ← in.
- FULL with !in_fire & out_fire → EMPTY.
- FULL with neither → hold.
- SKID: out_fire → FULL, and main ← skid. Otherwise hold.
- flush has highest priority. Next state is EMPTY, any in_fire in that cycle is discarded, and the control bits of both entries are cleared.
- Control gating: out_br_taken/out_mem_r_en/out_mem_w_en/out_wb_en are forced 0 whenever out_valid = 0. Payload outputs hold their last main value when out_valid = 0.
- in_br_taken is stored as a clean 0/1. X or Z on the input is not propagated past reset.
- Ordering is strictly FIFO. No entry is duplicated or dropped except on flush.

## Timing
- Reset: state EMPTY, all entries and outputs 0, in_ready = 1, out_valid = 0, occupancy = 0.
- in_fire while rst is asserted is ignored.
- Latency: in_fire in cycle N → out_valid with that payload in cycle N+1.
- Throughput: 1 instruction per cycle while out_ready = 1.
- in_ready deasserts the cycle after the skid entry fills. The instruction accepted in that filling cycle is never lost.
- flush with out_ready = 1 in the same cycle: the main entry is still considered consumed by EXE in that cycle. Next cycle out_valid = 0.
- Reset mid-transfer returns to EMPTY immediately, with no flush cycle needed.

## Structure
- Package id_exe_pkg holds the default widths (DATA_W_DEF = 32, RADDR_W_DEF = 5, CMD_W_DEF = 5) and the FSM state enum {EMPTY, FULL, SKID}.
- Sub-module pipe_skid_buf (parameter WIDTH) implements the FSM and both entries over a packed bus.
- id_exe_pipe_reg packs and unpacks the fields, applies control gating, and derives occupancy.
- Control bits are packed at fixed LSB positions so the flush clear is a masked write.

## Test plan
- Reset then stream: 4 instructions PC = 0x00, 0x04, 0x08, 0x0C with out_ready = 1 → outputs appear one cycle later, in order, occupancy = 1 throughout.
- Back-pressure: out_ready = 0 with 2 instructions sent → occupancy = 2, in_ready = 0. Release → PC 0x10 then 0x14, in_ready = 1 one cycle after the first out_fire.
- Flush while in SKID holding wb_en = 1, mem_w_en = 1 → next cycle out_valid = 0, all four control outputs 0, occupancy = 0, and the simultaneous in_fire is dropped.
- Gating: EMPTY after an instruction with mem_r_en = 1 retired → out_mem_r_en = 0 while out_pc holds its last value.
- Async reset asserted mid-cycle while in SKID → outputs 0 and in_ready = 1 without waiting for a clock edge.
- Parameter sweep: DATA_W = 64, RADDR_W = 6, CMD_W = 4 with random valid/ready → scoreboard shows no loss, duplication, or reordering over 10k transactions.

Source files
------------

// File: rtl/id_exe_pkg.sv
// Shared widths and FSM encoding for the ID->EXE pipeline register.
package id_exe_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int CMD_W_DEF   = 5;

  // br_taken, mem_r_en, mem_w_en, wb_en occupy the low bits of the packed bus
  localparam int CTRL_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer over an opaque packed bus; the low CLR_W
// bits of each entry are cleared on flush.
module pipe_skid_buf
  import id_exe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CLR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       state_dbg
);

  // Handshake: a transfer happens on a side exactly when valid & ready are both
  // high at the rising edge; ready and valid here decode only the state register.
  localparam logic [WIDTH-1:0] CLR_MASK = {{(WIDTH-CLR_W){1'b0}}, {CLR_W{1'b1}}};

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign in_ready  = (state_q != SKID);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign state_dbg = state_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = FULL;
          main_d  = in_data;
        end
      end
      FULL: begin
        case ({in_fire, out_fire})
          2'b11: main_d = in_data;
          2'b10: begin
            state_d = SKID;
            skid_d  = in_data;
          end
          2'b01: state_d = EMPTY;
          default: ;
        endcase
      end
      SKID: begin
        if (out_fire) begin
          state_d = FULL;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops any concurrent accept; payload is kept but control bits die.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q & ~CLR_MASK;
      skid_d  = skid_q & ~CLR_MASK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register: packs the decode payload into a skid buffer and
// gates the control bits with out_valid on the EXE side.
module id_exe_pipe_reg
  import id_exe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int CMD_W   = CMD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_pc,
  input  logic [DATA_W-1:0]  in_val1,
  input  logic [DATA_W-1:0]  in_val2,
  input  logic [DATA_W-1:0]  in_reg2,
  input  logic [RADDR_W-1:0] in_dest,
  input  logic [CMD_W-1:0]   in_exe_cmd,
  input  logic               in_br_taken,
  input  logic               in_mem_r_en,
  input  logic               in_mem_w_en,
  input  logic               in_wb_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_pc,
  output logic [DATA_W-1:0]  out_val1,
  output logic [DATA_W-1:0]  out_val2,
  output logic [DATA_W-1:0]  out_reg2,
  output logic [RADDR_W-1:0] out_dest,
  output logic [CMD_W-1:0]   out_exe_cmd,
  output logic               out_br_taken,
  output logic               out_mem_r_en,
  output logic               out_mem_w_en,
  output logic               out_wb_en,
  output logic [1:0]         occupancy
);

  localparam int PW = 4 * DATA_W + RADDR_W + CMD_W + CTRL_W;

  logic [PW-1:0]     in_bus, out_bus;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        state_dbg;
  logic              br_clean;

  // Anything other than a definite 1 is stored as 0.
  always_comb begin
    br_clean = 1'b0;
    if (in_br_taken) br_clean = 1'b1;
  end

  assign in_bus = {in_pc, in_val1, in_val2, in_reg2, in_dest, in_exe_cmd,
                   br_clean, in_mem_r_en, in_mem_w_en, in_wb_en};

  pipe_skid_buf #(
    .WIDTH (PW),
    .CLR_W (CTRL_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_bus),
    .state_dbg (state_dbg)
  );

  assign {out_pc, out_val1, out_val2, out_reg2, out_dest, out_exe_cmd, out_ctrl} = out_bus;

  assign out_br_taken = out_ctrl[3] & out_valid;
  assign out_mem_r_en = out_ctrl[2] & out_valid;
  assign out_mem_w_en = out_ctrl[1] & out_valid;
  assign out_wb_en    = out_ctrl[0] & out_valid;

  always_comb begin
    occupancy = 2'd0;
    case (state_dbg)
      FULL:    occupancy = 2'd1;
      SKID:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Directed bench for id_exe_pipe_reg plus a randomized FIFO-order run on a
// wide-parameter instance.
module tb_id_exe_pipe_reg;

  localparam int DW = 32, RW = 5, CW = 5;
  localparam int R_DW = 64, R_RW = 6, R_CW = 4;
  localparam int R_PW = 4 * R_DW + R_RW + R_CW + 4;
  localparam int N_RAND = 10000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Directed instance
  logic          flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_pc, in_val1, in_val2, in_reg2, out_pc, out_val1, out_val2, out_reg2;
  logic [RW-1:0] in_dest, out_dest;
  logic [CW-1:0] in_exe_cmd, out_exe_cmd;
  logic          in_br_taken, in_mem_r_en, in_mem_w_en, in_wb_en;
  logic          out_br_taken, out_mem_r_en, out_mem_w_en, out_wb_en;
  logic [1:0]    occupancy;

  // Wide-parameter instance
  logic            r_flush, r_in_valid, r_in_ready, r_out_valid, r_out_ready;
  logic [R_DW-1:0] r_in_pc, r_in_val1, r_in_val2, r_in_reg2;
  logic [R_DW-1:0] r_out_pc, r_out_val1, r_out_val2, r_out_reg2;
  logic [R_RW-1:0] r_in_dest, r_out_dest;
  logic [R_CW-1:0] r_in_exe_cmd, r_out_exe_cmd;
  logic            r_in_br, r_in_mr, r_in_mw, r_in_wb;
  logic            r_out_br, r_out_mr, r_out_mw, r_out_wb;
  logic [1:0]      r_occupancy;

  logic [R_PW-1:0] exp_q[$];

  id_exe_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_val1(in_val1), .in_val2(in_val2), .in_reg2(in_reg2),
    .in_dest(in_dest), .in_exe_cmd(in_exe_cmd),
    .in_br_taken(in_br_taken), .in_mem_r_en(in_mem_r_en),
    .in_mem_w_en(in_mem_w_en), .in_wb_en(in_wb_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_val1(out_val1), .out_val2(out_val2), .out_reg2(out_reg2),
    .out_dest(out_dest), .out_exe_cmd(out_exe_cmd),
    .out_br_taken(out_br_taken), .out_mem_r_en(out_mem_r_en),
    .out_mem_w_en(out_mem_w_en), .out_wb_en(out_wb_en),
    .occupancy(occupancy)
  );

  id_exe_pipe_reg #(.DATA_W(R_DW), .RADDR_W(R_RW), .CMD_W(R_CW)) dut_wide (
    .clk(clk), .rst(rst), .flush(r_flush),
    .in_valid(r_in_valid), .in_ready(r_in_ready),
    .in_pc(r_in_pc), .in_val1(r_in_val1), .in_val2(r_in_val2), .in_reg2(r_in_reg2),
    .in_dest(r_in_dest), .in_exe_cmd(r_in_exe_cmd),
    .in_br_taken(r_in_br), .in_mem_r_en(r_in_mr),
    .in_mem_w_en(r_in_mw), .in_wb_en(r_in_wb),
    .out_valid(r_out_valid), .out_ready(r_out_ready),
    .out_pc(r_out_pc), .out_val1(r_out_val1), .out_val2(r_out_val2), .out_reg2(r_out_reg2),
    .out_dest(r_out_dest), .out_exe_cmd(r_out_exe_cmd),
    .out_br_taken(r_out_br), .out_mem_r_en(r_out_mr),
    .out_mem_w_en(r_out_mw), .out_wb_en(r_out_wb),
    .occupancy(r_occupancy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ctrl = {br_taken, mem_r_en, mem_w_en, wb_en}
  task automatic drive(input logic valid, input logic [DW-1:0] pc, input logic [3:0] ctrl);
    in_valid    = valid;
    in_pc       = pc;
    in_val1     = pc + 32'd100;
    in_val2     = ~pc;
    in_reg2     = pc << 1;
    in_dest     = pc[6:2];
    in_exe_cmd  = pc[4:0] ^ 5'h1f;
    in_br_taken = ctrl[3];
    in_mem_r_en = ctrl[2];
    in_mem_w_en = ctrl[1];
    in_wb_en    = ctrl[0];
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h0000_0abc, 4'b1111);
    out_ready = 1'b0;
    step();
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || occupancy !== 2'd0 || out_pc !== 32'd0 || out_wb_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b occ=%0d out_pc=%h wb=%b, required 1 0 0 0 0",
               in_ready, out_valid, occupancy, out_pc, out_wb_en);
    end
    drive(1'b0, 32'd0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if (occupancy !== 2'd0) begin
      failures++;
      $display("FAIL reset_ignores_in: occ=%0d, required 0", occupancy);
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] pc;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4);
      drive(1'b1, pc, 4'b0001);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== pc || out_val1 !== pc + 32'd100 || out_dest !== pc[6:2] ||
          out_exe_cmd !== (pc[4:0] ^ 5'h1f) || out_wb_en !== 1'b1 || occupancy !== 2'd1) begin
        failures++;
        $display("FAIL stream_%0d: valid=%b pc=%h val1=%h dest=%h cmd=%h wb=%b occ=%0d, required pc=%h occ=1",
                 i, out_valid, out_pc, out_val1, out_dest, out_exe_cmd, out_wb_en, occupancy, pc);
      end
    end
    drive(1'b0, 32'd0, 4'b0000);
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL stream_drain: valid=%b occ=%0d, required 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h10, 4'b0001);
    step();
    checks++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_first: occ=%0d in_ready=%b, required 1 1", occupancy, in_ready);
    end
    drive(1'b1, 32'h14, 4'b0001);
    step();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_pc !== 32'h10) begin
      failures++;
      $display("FAIL bp_skid: occ=%0d in_ready=%b pc=%h, required 2 0 00000010", occupancy, in_ready, out_pc);
    end
    // Offered while full: must not be taken
    drive(1'b1, 32'h99, 4'b0001);
    out_ready = 1'b1;
    step();
    drive(1'b0, 32'd0, 4'b0000);
    checks++;
    if (out_pc !== 32'h14 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      failures++;
      $display("FAIL bp_release: pc=%h in_ready=%b occ=%0d, required 00000014 1 1", out_pc, in_ready, occupancy);
    end
    step();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: occ=%0d valid=%b, required 0 0", occupancy, out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h20, 4'b0011);
    step();
    drive(1'b1, 32'h24, 4'b0011);
    step();
    flush = 1'b1;
    drive(1'b1, 32'h28, 4'b0011);
    step();
    flush = 1'b0;
    drive(1'b0, 32'd0, 4'b0000);
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 ||
        {out_br_taken, out_mem_r_en, out_mem_w_en, out_wb_en} !== 4'b0000) begin
      failures++;
      $display("FAIL flush_skid: valid=%b occ=%0d in_ready=%b ctrl=%b, required 0 0 1 0000",
               out_valid, occupancy, in_ready, {out_br_taken, out_mem_r_en, out_mem_w_en, out_wb_en});
    end
    step();
    checks++;
    if (occupancy !== 2'd0) begin
      failures++;
      $display("FAIL flush_skid_quiet: occ=%0d, required 0", occupancy);
    end
    // Flush in FULL with an accepting in_fire in the same cycle
    drive(1'b1, 32'h30, 4'b1001);
    step();
    flush = 1'b1;
    drive(1'b1, 32'h34, 4'b1001);
    step();
    flush = 1'b0;
    drive(1'b0, 32'd0, 4'b0000);
    checks++;
    if (occupancy !== 2'd0 || out_pc !== 32'h30 || out_br_taken !== 1'b0) begin
      failures++;
      $display("FAIL flush_full_drop: occ=%0d pc=%h br=%b, required 0 00000030 0", occupancy, out_pc, out_br_taken);
    end
    // Flush with out_ready high: main is consumed, nothing re-emerges
    out_ready = 1'b1;
    drive(1'b1, 32'h38, 4'b0001);
    step();
    flush = 1'b1;
    drive(1'b0, 32'd0, 4'b0000);
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL flush_with_ready: valid=%b occ=%0d, required 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_gating();
    out_ready = 1'b1;
    drive(1'b1, 32'h40, 4'b0100);
    step();
    drive(1'b0, 32'd0, 4'b0000);
    checks++;
    if (out_mem_r_en !== 1'b1 || out_pc !== 32'h40) begin
      failures++;
      $display("FAIL gating_live: mem_r=%b pc=%h, required 1 00000040", out_mem_r_en, out_pc);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_mem_r_en !== 1'b0 || out_pc !== 32'h40) begin
      failures++;
      $display("FAIL gating_empty: valid=%b mem_r=%b pc=%h, required 0 0 00000040", out_valid, out_mem_r_en, out_pc);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h50, 4'b0001);
    step();
    drive(1'b1, 32'h54, 4'b0001);
    step();
    drive(1'b0, 32'd0, 4'b0000);
    checks++;
    if (occupancy !== 2'd2) begin
      failures++;
      $display("FAIL async_setup: occ=%0d, required 2", occupancy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_pc !== 32'd0 || out_wb_en !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL async_reset: pc=%h wb=%b in_ready=%b valid=%b occ=%0d, required 0 0 1 0 0",
               out_pc, out_wb_en, in_ready, out_valid, occupancy);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_random();
    int sent, recv, cycles;
    logic [R_PW-1:0] got, exp;
    sent = 0;
    recv = 0;
    cycles = 0;
    exp_q.delete();
    while (recv < N_RAND && cycles < 60000) begin
      r_in_valid   = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
      r_in_pc      = {$urandom, $urandom};
      r_in_val1    = {$urandom, $urandom};
      r_in_val2    = {$urandom, $urandom};
      r_in_reg2    = {$urandom, $urandom};
      r_in_dest    = R_RW'($urandom);
      r_in_exe_cmd = R_CW'($urandom);
      {r_in_br, r_in_mr, r_in_mw, r_in_wb} = 4'($urandom);
      r_out_ready  = ($urandom_range(0, 3) != 0);
      if (r_out_valid && r_out_ready) begin
        got = {r_out_pc, r_out_val1, r_out_val2, r_out_reg2, r_out_dest, r_out_exe_cmd,
               r_out_br, r_out_mr, r_out_mw, r_out_wb};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra: output pc=%h with empty expected queue", r_out_pc);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL rand_order_%0d: got pc=%h ctrl=%b, required pc=%h ctrl=%b",
                     recv, r_out_pc, {r_out_br, r_out_mr, r_out_mw, r_out_wb},
                     exp[R_PW-1 -: R_DW], exp[3:0]);
          end
        end
        recv++;
      end
      if (r_in_valid && r_in_ready) begin
        exp_q.push_back({r_in_pc, r_in_val1, r_in_val2, r_in_reg2, r_in_dest, r_in_exe_cmd,
                         r_in_br, r_in_mr, r_in_mw, r_in_wb});
        sent++;
      end
      step();
      cycles++;
    end
    r_in_valid  = 1'b0;
    r_out_ready = 1'b1;
    checks++;
    if (recv != N_RAND || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rand_count: received=%0d pending=%0d after %0d cycles, required %0d 0",
               recv, exp_q.size(), cycles, N_RAND);
    end
    step();
    step();
    checks++;
    if (r_out_valid !== 1'b0 || r_occupancy !== 2'd0) begin
      failures++;
      $display("FAIL rand_no_dup: valid=%b occ=%0d, required 0 0", r_out_valid, r_occupancy);
    end
  endtask

  initial begin
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'd0, 4'b0000);
    r_flush = 1'b0;
    r_in_valid = 1'b0;
    r_out_ready = 1'b0;
    r_in_pc = '0; r_in_val1 = '0; r_in_val2 = '0; r_in_reg2 = '0;
    r_in_dest = '0; r_in_exe_cmd = '0;
    {r_in_br, r_in_mr, r_in_mw, r_in_wb} = 4'b0000;

    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_gating();
    test_async_reset();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
